// File: rtl/fwd_hazard_unit_param.sv
// Forwarding-select and load-use stall unit for the pipelined RISC-V core.
// Tracks in-flight destinations over DEPTH post-EX stages and counts stall/forward cycles.
module fwd_hazard_unit_param #(
    parameter int AW       = 5,
    parameter int NUM_SRC  = 2,
    parameter int DEPTH    = 2,
    parameter int LOAD_LAT = 1,
    parameter int FW       = $clog2(DEPTH + 1),
    parameter int CW       = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   ex_valid_i,
    input  logic [AW-1:0]          ex_rd_i,
    input  logic                   ex_regwrite_i,
    input  logic                   ex_memread_i,
    input  logic [NUM_SRC*AW-1:0]  ex_rs_i,
    input  logic                   id_valid_i,
    input  logic [NUM_SRC*AW-1:0]  id_rs_i,
    input  logic [NUM_SRC-1:0]     id_rs_used_i,
    output logic [NUM_SRC*FW-1:0]  fwd_sel_o,
    output logic                   stall_o,
    output logic [CW-1:0]          stall_cnt_o,
    output logic [CW-1:0]          fwd_cnt_o
);

    typedef struct packed {
        logic          v;
        logic [AW-1:0] rd;
        logic          wr;
        logic          ld;
    } hist_t;

    hist_t                 hist [DEPTH];
    logic [DEPTH-1:0]      stage_wr;
    logic                  ex_writes;
    logic [NUM_SRC*FW-1:0] fwd_sel;
    logic [NUM_SRC-1:0]    src_stall;
    logic                  hit_ld;
    logic                  hit_early;
    logic                  stall;
    logic [CW-1:0]         stall_cnt;
    logic [CW-1:0]         fwd_cnt;

    // The history shifts every cycle; stalls reach it as bubbles on ex_valid_i.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int s = 0; s < DEPTH; s++) begin
                hist[s] <= '0;
            end
        end else begin
            hist[0] <= {ex_valid_i, ex_rd_i, ex_regwrite_i, ex_memread_i};
            for (int s = 1; s < DEPTH; s++) begin
                hist[s] <= hist[s-1];
            end
        end
    end

    always_comb begin
        for (int s = 0; s < DEPTH; s++) begin
            stage_wr[s] = hist[s].v & hist[s].wr & (hist[s].rd != '0);
        end
    end

    assign ex_writes = ex_valid_i & ex_regwrite_i & (ex_rd_i != '0);

    // Oldest-to-youngest scan so the youngest matching writer overwrites older ones.
    always_comb begin
        fwd_sel = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            for (int s = DEPTH - 1; s >= 0; s--) begin
                if (stage_wr[s] && (hist[s].rd == ex_rs_i[j*AW +: AW])) begin
                    fwd_sel[j*FW +: FW] = FW'(DEPTH - s);
                end
            end
        end
        if (!rst_i) begin
            fwd_sel = '0;
        end
    end

    // Only the nearest writer counts; EX is nearest of all, so a younger ALU op masks an older load.
    always_comb begin
        src_stall = '0;
        hit_ld    = 1'b0;
        hit_early = 1'b0;
        for (int j = 0; j < NUM_SRC; j++) begin
            hit_ld    = 1'b0;
            hit_early = 1'b0;
            for (int s = DEPTH - 1; s >= 0; s--) begin
                if (stage_wr[s] && (hist[s].rd == id_rs_i[j*AW +: AW])) begin
                    hit_ld    = hist[s].ld;
                    hit_early = (s + 1 < LOAD_LAT);
                end
            end
            if (ex_writes && (ex_rd_i == id_rs_i[j*AW +: AW])) begin
                hit_ld    = ex_memread_i;
                hit_early = (LOAD_LAT > 0);
            end
            src_stall[j] = id_valid_i & id_rs_used_i[j] & (id_rs_i[j*AW +: AW] != '0)
                           & hit_ld & hit_early;
        end
    end

    assign stall = rst_i & (|src_stall);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CW'(1);
            end
            if ((|fwd_sel) && (fwd_cnt != '1)) begin
                fwd_cnt <= fwd_cnt + CW'(1);
            end
        end
    end

    assign fwd_sel_o   = fwd_sel;
    assign stall_o     = stall;
    assign stall_cnt_o = stall_cnt;
    assign fwd_cnt_o   = fwd_cnt;

endmodule

// File: tb/tb_fwd_hazard_unit_param.sv
// Bench for fwd_hazard_unit_param: three configurations share one stimulus stream and are
// compared each cycle against a record-of-past-instructions reference model.
module tb_fwd_hazard_unit_param;

    logic       clk;
    logic       rst;
    logic       ex_valid;
    logic [4:0] ex_rd;
    logic       ex_wr;
    logic       ex_ld;
    logic [9:0] ex_rs;
    logic       id_valid;
    logic [9:0] id_rs;
    logic [1:0] used;

    logic [3:0]  sel_a;
    logic [3:0]  sel_b;
    logic [1:0]  sel_c;
    logic        stall_a, stall_b, stall_c;
    logic [31:0] scnt_a, fcnt_a;
    logic [3:0]  scnt_b, fcnt_b;
    logic [7:0]  scnt_c, fcnt_c;

    int assertions = 0;
    int failures   = 0;

    typedef struct {
        bit v;
        int rd;
        bit wr;
        bit ld;
    } rec_t;

    // past[k] is the instruction that sat in EX k+1 cycles ago
    rec_t   past [3];
    longint m_scnt [3];
    longint m_fcnt [3];
    int     dep [3]   = '{2, 3, 1};
    int     lat [3]   = '{1, 2, 0};
    longint cmax [3]  = '{64'hFFFF_FFFF, 64'hF, 64'hFF};

    fwd_hazard_unit_param #(.DEPTH(2), .LOAD_LAT(1), .CW(32)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .ex_valid_i(ex_valid), .ex_rd_i(ex_rd), .ex_regwrite_i(ex_wr), .ex_memread_i(ex_ld),
        .ex_rs_i(ex_rs), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rs_used_i(used),
        .fwd_sel_o(sel_a), .stall_o(stall_a), .stall_cnt_o(scnt_a), .fwd_cnt_o(fcnt_a)
    );

    fwd_hazard_unit_param #(.DEPTH(3), .LOAD_LAT(2), .CW(4)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .ex_valid_i(ex_valid), .ex_rd_i(ex_rd), .ex_regwrite_i(ex_wr), .ex_memread_i(ex_ld),
        .ex_rs_i(ex_rs), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rs_used_i(used),
        .fwd_sel_o(sel_b), .stall_o(stall_b), .stall_cnt_o(scnt_b), .fwd_cnt_o(fcnt_b)
    );

    fwd_hazard_unit_param #(.DEPTH(1), .LOAD_LAT(0), .CW(8)) dut_c (
        .clk_i(clk), .rst_i(rst),
        .ex_valid_i(ex_valid), .ex_rd_i(ex_rd), .ex_regwrite_i(ex_wr), .ex_memread_i(ex_ld),
        .ex_rs_i(ex_rs), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rs_used_i(used),
        .fwd_sel_o(sel_c), .stall_o(stall_c), .stall_cnt_o(scnt_c), .fwd_cnt_o(fcnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Distance code of the youngest earlier instruction that writes rs
    function automatic int exp_fwd(int d, int rs);
        if (!rst || rs == 0) return 0;
        for (int k = 0; k < d; k++) begin
            if (past[k].v && past[k].wr && past[k].rd == rs) return d - k;
        end
        return 0;
    endfunction

    // Stall when the nearest producer of a used ID source is a load whose data is not yet ready
    function automatic bit exp_stall(int d, int ll);
        int rs;
        int pos;
        bit ld;
        bit found;
        if (!rst || !id_valid) return 0;
        for (int j = 0; j < 2; j++) begin
            rs    = int'(id_rs[j*5 +: 5]);
            found = 0;
            pos   = 0;
            ld    = 0;
            if (used[j] && rs != 0) begin
                if (ex_valid && ex_wr && int'(ex_rd) == rs) begin
                    found = 1;
                    pos   = -1;
                    ld    = ex_ld;
                end else begin
                    for (int k = 0; k < d; k++) begin
                        if (!found && past[k].v && past[k].wr && past[k].rd == rs) begin
                            found = 1;
                            pos   = k;
                            ld    = past[k].ld;
                        end
                    end
                end
                if (found && ld && pos + 1 < ll) return 1;
            end
        end
        return 0;
    endfunction

    task automatic updateModel();
        if (!rst) begin
            for (int k = 0; k < 3; k++) past[k].v = 0;
            for (int i = 0; i < 3; i++) begin
                m_scnt[i] = 0;
                m_fcnt[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (exp_stall(dep[i], lat[i]) && m_scnt[i] < cmax[i]) m_scnt[i]++;
                if ((exp_fwd(dep[i], int'(ex_rs[4:0])) != 0 || exp_fwd(dep[i], int'(ex_rs[9:5])) != 0)
                    && m_fcnt[i] < cmax[i]) m_fcnt[i]++;
            end
            for (int k = 2; k >= 1; k--) past[k] = past[k-1];
            past[0] = '{v: ex_valid, rd: int'(ex_rd), wr: ex_wr, ld: ex_ld};
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        assertions++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic checkOutput();
        for (int j = 0; j < 2; j++) begin
            chk($sformatf("a_sel%0d", j), 64'(sel_a[j*2 +: 2]), 64'(exp_fwd(2, int'(ex_rs[j*5 +: 5]))));
            chk($sformatf("b_sel%0d", j), 64'(sel_b[j*2 +: 2]), 64'(exp_fwd(3, int'(ex_rs[j*5 +: 5]))));
            chk($sformatf("c_sel%0d", j), 64'(sel_c[j]),        64'(exp_fwd(1, int'(ex_rs[j*5 +: 5]))));
        end
        chk("a_stall", 64'(stall_a), 64'(exp_stall(2, 1)));
        chk("b_stall", 64'(stall_b), 64'(exp_stall(3, 2)));
        chk("c_stall", 64'(stall_c), 64'(exp_stall(1, 0)));
        chk("a_scnt", 64'(scnt_a), m_scnt[0]);
        chk("a_fcnt", 64'(fcnt_a), m_fcnt[0]);
        chk("b_scnt", 64'(scnt_b), m_scnt[1]);
        chk("b_fcnt", 64'(fcnt_b), m_fcnt[1]);
        chk("c_scnt", 64'(scnt_c), m_scnt[2]);
        chk("c_fcnt", 64'(fcnt_c), m_fcnt[2]);
    endtask

    // Account for the edge that ends the previous step, then drive the new step and check it
    task automatic applyStimulus(input bit r, input bit ev, input int erd, input bit ewr,
                                 input bit eld, input int ers0, input int ers1, input bit iv,
                                 input int irs0, input int irs1, input int iu);
        @(posedge clk);
        updateModel();
        @(negedge clk);
        rst      = r;
        ex_valid = ev;
        ex_rd    = 5'(erd);
        ex_wr    = ewr;
        ex_ld    = eld;
        ex_rs    = {5'(ers1), 5'(ers0)};
        id_valid = iv;
        id_rs    = {5'(irs1), 5'(irs0)};
        used     = 2'(iu);
        #1;
        checkOutput();
    endtask

    initial begin
        rst = 1'b0; ex_valid = 1'b0; ex_rd = '0; ex_wr = 1'b0; ex_ld = 1'b0;
        ex_rs = '0; id_valid = 1'b0; id_rs = '0; used = '0;

        applyStimulus(0, 0,0,0,0, 0,0, 0,0,0,0);
        applyStimulus(0, 1,5,1,1, 5,5, 1,5,5,3);
        chk("rst_stall", 64'(stall_a), 64'd0);
        chk("rst_sel", 64'(sel_a), 64'd0);
        chk("rst_scnt", 64'(scnt_a), 64'd0);

        // Forward from stage0, then stage1, then retired
        applyStimulus(1, 1,5,1,0, 0,0, 0,0,0,0);
        applyStimulus(1, 1,0,0,0, 5,0, 0,0,0,0);
        chk("fwd_stage0", 64'(sel_a[1:0]), 64'd2);
        applyStimulus(1, 0,0,0,0, 5,0, 0,0,0,0);
        chk("fwd_stage1", 64'(sel_a[1:0]), 64'd1);
        applyStimulus(1, 0,0,0,0, 5,0, 0,0,0,0);
        chk("fwd_retired", 64'(sel_a[1:0]), 64'd0);

        // Youngest writer wins; x0 never forwards
        applyStimulus(1, 1,7,1,0, 0,0, 0,0,0,0);
        applyStimulus(1, 1,7,1,0, 0,0, 0,0,0,0);
        applyStimulus(1, 1,0,1,0, 0,7, 0,0,0,0);
        chk("fwd_youngest", 64'(sel_a[3:2]), 64'd2);
        applyStimulus(1, 0,0,0,0, 0,7, 0,0,0,0);
        chk("fwd_x0", 64'(sel_a[1:0]), 64'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0,0,0,0, 0,0, 0,0,0,0);

        // Load-use: one stall cycle for LOAD_LAT=1, two for LOAD_LAT=2, none for LOAD_LAT=0
        applyStimulus(1, 1,3,1,1, 0,0, 1,3,0,1);
        chk("lu_stall_a", 64'(stall_a), 64'd1);
        chk("lu_stall_b", 64'(stall_b), 64'd1);
        chk("lu_stall_c", 64'(stall_c), 64'd0);
        applyStimulus(1, 0,0,0,0, 3,0, 1,3,0,1);
        chk("lu_release_a", 64'(stall_a), 64'd0);
        chk("lu_fwd_a", 64'(sel_a[1:0]), 64'd2);
        chk("lu_hold_b", 64'(stall_b), 64'd1);
        applyStimulus(1, 0,0,0,0, 0,0, 1,3,0,1);
        chk("lu_release_b", 64'(stall_b), 64'd0);
        chk("lu_scnt_a", 64'(scnt_a), 64'd1);
        chk("lu_scnt_b", 64'(scnt_b), 64'd2);

        // Younger ALU writer masks an older load
        applyStimulus(1, 1,9,1,1, 0,0, 0,0,0,0);
        applyStimulus(1, 1,9,1,0, 0,0, 1,0,9,2);
        chk("mask_b", 64'(stall_b), 64'd0);

        // Unused source or empty ID never stalls
        applyStimulus(1, 1,3,1,1, 0,0, 1,3,0,0);
        chk("unused_a", 64'(stall_a), 64'd0);
        applyStimulus(1, 1,3,1,1, 0,0, 0,3,0,1);
        chk("idinv_a", 64'(stall_a), 64'd0);

        // Reset during a stall
        applyStimulus(1, 1,4,1,1, 0,0, 1,4,0,1);
        chk("pre_rst_stall", 64'(stall_a), 64'd1);
        applyStimulus(0, 1,4,1,1, 4,0, 1,4,0,1);
        chk("in_rst_stall", 64'(stall_a), 64'd0);
        chk("in_rst_sel", 64'(sel_a), 64'd0);
        applyStimulus(1, 0,0,0,0, 4,0, 1,4,0,1);
        chk("post_rst_sel", 64'(sel_a), 64'd0);
        chk("post_rst_scnt", 64'(scnt_a), 64'd0);
        chk("post_rst_fcnt", 64'(fcnt_a), 64'd0);

        // Saturation of the 4-bit counters
        for (int i = 0; i < 20; i++) applyStimulus(1, 1,6,1,1, 6,0, 1,6,0,1);
        applyStimulus(1, 0,0,0,0, 0,0, 0,0,0,0);
        chk("sat_scnt_b", 64'(scnt_b), 64'hF);
        chk("sat_fcnt_b", 64'(fcnt_b), 64'hF);
        chk("nosat_scnt_a", 64'(scnt_a), 64'd20);

        // Random traffic over a small register window to make hits frequent
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 39) != 0,
                          $urandom_range(0, 3) != 0, $urandom_range(0, 7),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                          $urandom_range(0, 7), $urandom_range(0, 7),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 7),
                          $urandom_range(0, 7), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
